itf_host_agent: RTL
===================

# itf_host_agent

Synthesizable host-side agent for the chip's off-chip data interface, replacing the behavioural DRAM model used to drive TOP. Serves ISA fetches for `NUM_OP` config-ready channels with round-robin arbitration and persistent per-channel cursors, and executes chip-issued data commands (memory to chip, chip to memory) against a synchronous local SRAM. All transfers use valid/ready handshakes with a 2-entry read-return buffer that sustains one word per cycle.

## Interface
- `PORT_WIDTH`, 128: interface word width.
- `NUM_OP`, 6: number of ISA channels.
- `MEM_AW`, 18: SRAM word-address width.
- `LEN_W`, 16: transfer length width, in words.
- `ISA_DEPTH`, 64: per-channel ISA region size in words; the cursor wraps at this value.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_rdy` in NUM_OP: per-channel ISA request (chip O_CfgRdy).
- `isa_base` in NUM_OP*MEM_AW: per-channel region base; static while `busy`.
- `isa_num` in NUM_OP*LEN_W: words per ISA grant; static while `busy`.
- `cmd_vld` in 1: chip has a data command pending.
- `dat_oe` in 1: chip drives the bus.
- `dat_in` in PORT_WIDTH: bus from chip.
- `dat_in_vld` in 1: chip word valid.
- `dat_in_rdy` out 1: agent accepts chip word.
- `dat_out` out PORT_WIDTH: word to chip.
- `dat_out_vld` out 1: word valid.
- `dat_out_last` out 1: final word of burst.
- `dat_out_rdy` in 1: chip accepts word.
- `isa_vld` out 1: current burst is ISA.
- `mem_ren` out 1, `mem_raddr` out MEM_AW, `mem_rdata` in PORT_WIDTH: read port; data arrives 1 cycle after `mem_ren`.
- `mem_wen` out 1, `mem_waddr` out MEM_AW, `mem_wdata` out PORT_WIDTH: write port.
- `busy` out 1: state is not IDLE.
- `err_zero` out 1: one-cycle pulse when a zero-length command or grant completes.

## Operation
- States: IDLE, ISA, CMD, RD, WR.
- IDLE:
  - If `cmd_vld` is set, go to CMD. Commands take priority over `cfg_rdy`.
  - Otherwise, if `|cfg_rdy`, grant the first set bit after the last-granted index (round-robin) and go to ISA.
- ISA:
  - Stream `isa_num[g]` words from address `isa_base[g] + cur[g]`.
  - `cur[g]` increments per word issued and wraps to 0 when it reaches `ISA_DEPTH`.
  - Cursors persist across grants.
  - After the last handshake, return to IDLE. The round-robin pointer is updated to `g`.
- CMD:
  - `dat_in_rdy = dat_oe & cmd_vld`. The handshake captures the command fields:
    - `dir = dat_in[0]` (1 = chip to memory).
    - `addr = dat_in[1 +: MEM_AW]`.
    - `len = dat_in[1+MEM_AW +: LEN_W]`.
  - Next state is WR if `dir` is 1, else RD.
- RD: stream `len` words from `addr` to the chip, with `isa_vld` = 0.
- WR:
  - `dat_in_rdy = dat_oe`.
  - Each `dat_in_vld & dat_in_rdy` writes `dat_in` to `addr + k`, with `mem_wen` in the same cycle.
  - After `len` words, return to IDLE.
- Read engine (ISA and RD):
  - Issue `mem_ren` only when outstanding reads plus buffered words are fewer than 2.
  - `dat_out` is the buffer head.
  - `dat_out_last` is high exactly on the final word.
- Zero length (`len` = 0 or `isa_num[g]` = 0):
  - No memory access and no data handshake.
  - Pulse `err_zero` and return to IDLE the next cycle. For ISA, the pointer still advances.
- All address arithmetic is modulo 2^MEM_AW. `addr + len` may wrap past the top of memory.

## Timing
- Reset values:
  - Every output is 0 and state is IDLE.
  - Cursors are 0 and the buffer is empty.
  - The pointer is NUM_OP-1, so channel 0 wins first.
- Reset mid-burst aborts the burst immediately. No further `mem_wen` or `dat_out_vld` is issued after reset assertion.
- Entry to ISA or RD at cycle T:
  - `mem_ren` is asserted at T.
  - `dat_out_vld` first rises at T+1.
  - With `dat_out_rdy` held high, the burst runs 1 word/cycle and N words complete at T+N.
- Backpressure: when `dat_out_rdy` is low, `dat_out` and `dat_out_vld` hold stable and the buffer never overflows.
- IDLE decision to first state cycle takes 1 cycle. The last handshake returns to IDLE the next cycle.
- WR has zero write latency: `mem_wen` is asserted in the handshake cycle.
- `cfg_rdy` changing during a burst has no effect until IDLE.

## Test plan
- Reset, then `cfg_rdy` = 6'b100101 with `isa_num` = 2 each → grants in order 0, 2, 5, 0. Channel 0's second grant reads `base0+2` and `base0+3`.
- `ISA_DEPTH` = 4, `isa_num[1]` = 3, two grants → addresses `b+0..2`, then `b+3, b+0, b+1`.
- RD command with addr 0x3FFFE, len 4 and random `dat_out_rdy` stalls → words from 0x3FFFE, 0x3FFFF, 0x0, 0x1 in order. `dat_out_last` is high only on the 4th word, with no loss or duplication.
- WR command with addr 0x100, len 3, `dat_in_vld` gapped → `mem_wen` fires 3 times at 0x100..0x102, then return to IDLE.
- `cmd_vld` and `cfg_rdy` rise in the same cycle → CMD is served first, then ISA. A len = 0 command pulses `err_zero` once with no memory access.
- `rst_n` asserted on the 2nd word of an 8-word RD → all outputs are 0 immediately. After release, a new grant starts from cursor 0.

Source files
------------

// File: rtl/itf_host_agent.sv
// itf_host_agent: host-side agent for the chip's off-chip data interface.
// It serves round-robin ISA fetches from per-channel cursors and executes
// chip-issued memory-to-chip / chip-to-memory commands against a synchronous
// SRAM. Reads go through a 2-entry return buffer that sustains one word/cycle.
module itf_host_agent #(
   parameter int PORT_WIDTH = 128,
   parameter int NUM_OP     = 6,
   parameter int MEM_AW     = 18,
   parameter int LEN_W      = 16,
   parameter int ISA_DEPTH  = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_OP-1:0]          cfg_rdy,
   input  logic [NUM_OP*MEM_AW-1:0]   isa_base,
   input  logic [NUM_OP*LEN_W-1:0]    isa_num,
   input  logic                       cmd_vld,
   input  logic                       dat_oe,
   input  logic [PORT_WIDTH-1:0]      dat_in,
   input  logic                       dat_in_vld,
   output logic                       dat_in_rdy,
   output logic [PORT_WIDTH-1:0]      dat_out,
   output logic                       dat_out_vld,
   output logic                       dat_out_last,
   input  logic                       dat_out_rdy,
   output logic                       isa_vld,
   output logic                       mem_ren,
   output logic [MEM_AW-1:0]          mem_raddr,
   input  logic [PORT_WIDTH-1:0]      mem_rdata,
   output logic                       mem_wen,
   output logic [MEM_AW-1:0]          mem_waddr,
   output logic [PORT_WIDTH-1:0]      mem_wdata,
   output logic                       busy,
   output logic                       err_zero
);

   localparam int GW = (NUM_OP > 1) ? $clog2(NUM_OP) : 1;
   localparam int CW = (ISA_DEPTH > 1) ? $clog2(ISA_DEPTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISA,
      S_CMD,
      S_RD,
      S_WR
   } state_t;

   state_t                  state_q, state_d;
   logic [GW-1:0]           ptr_q, ptr_d;
   logic [GW-1:0]           grant_q, grant_d;
   logic [CW-1:0]           cur_q [NUM_OP];
   logic [CW-1:0]           cur_d [NUM_OP];
   logic [MEM_AW-1:0]       addr_q, addr_d;
   logic [LEN_W-1:0]        issueLeft_q, issueLeft_d;
   logic [LEN_W-1:0]        deliverLeft_q, deliverLeft_d;
   logic                    inflight_q, inflight_d;
   logic [1:0]              bufCnt_q, bufCnt_d;
   logic [PORT_WIDTH-1:0]   buf0_q, buf0_d;
   logic [PORT_WIDTH-1:0]   buf1_q, buf1_d;

   logic                    rrHit;
   logic [GW-1:0]           rrIdx;
   logic [MEM_AW-1:0]       isaAddr;
   logic [MEM_AW-1:0]       rdAddr;
   logic                    reading;
   logic                    avail;
   logic [PORT_WIDTH-1:0]   head;
   logic                    outVld;
   logic                    pop;
   logic                    issue;
   logic                    cmdHs;
   logic                    wrHs;
   logic                    zeroLen;

   // Round-robin pick: first requesting channel strictly after the last grant
   always_comb begin
      int idx;
      rrHit = 1'b0;
      rrIdx = '0;
      idx   = 0;
      for (int k = 1; k <= NUM_OP; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NUM_OP) idx = idx - NUM_OP;
         if (!rrHit && cfg_rdy[idx]) begin
            rrHit = 1'b1;
            rrIdx = GW'(idx);
         end
      end
   end

   // Datapath view of the read engine, write handshake and zero-length detect
   always_comb begin
      reading = (state_q == S_ISA) || (state_q == S_RD);
      isaAddr = isa_base[int'(grant_q)*MEM_AW +: MEM_AW] + MEM_AW'(cur_q[grant_q]);
      rdAddr  = (state_q == S_ISA) ? isaAddr : addr_q;
      avail   = (bufCnt_q != 2'd0) || inflight_q;
      head    = (bufCnt_q != 2'd0) ? buf0_q : mem_rdata;
      outVld  = reading && avail;
      pop     = outVld && dat_out_rdy;
      issue   = reading && (issueLeft_q != '0) &&
                ((bufCnt_q + {1'b0, inflight_q}) < 2'd2);
      zeroLen = ((state_q == S_ISA) || (state_q == S_RD) || (state_q == S_WR)) &&
                (deliverLeft_q == '0);
      dat_in_rdy = 1'b0;
      if (state_q == S_CMD)     dat_in_rdy = dat_oe && cmd_vld;
      else if (state_q == S_WR) dat_in_rdy = dat_oe && (deliverLeft_q != '0);
      cmdHs = (state_q == S_CMD) && dat_in_vld && dat_in_rdy;
      wrHs  = (state_q == S_WR) && dat_in_vld && dat_in_rdy;
   end

   // Output drive; addresses and data are forced to zero when not qualified
   always_comb begin
      dat_out_vld  = outVld;
      dat_out      = outVld ? head : '0;
      dat_out_last = outVld && (deliverLeft_q == LEN_W'(1));
      isa_vld      = (state_q == S_ISA);
      mem_ren      = issue;
      mem_raddr    = issue ? rdAddr : '0;
      mem_wen      = wrHs;
      mem_waddr    = wrHs ? addr_q : '0;
      mem_wdata    = wrHs ? dat_in : '0;
      busy         = (state_q != S_IDLE);
      err_zero     = zeroLen;
   end

   // Next-state logic: commands beat ISA requests; bursts end on the last word
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_vld)    state_d = S_CMD;
            else if (rrHit) state_d = S_ISA;
         end
         S_ISA, S_RD: begin
            if (zeroLen)                                      state_d = S_IDLE;
            else if (pop && (deliverLeft_q == LEN_W'(1)))     state_d = S_IDLE;
         end
         S_CMD: begin
            if (cmdHs) state_d = dat_in[0] ? S_WR : S_RD;
         end
         S_WR: begin
            if (zeroLen)                                      state_d = S_IDLE;
            else if (wrHs && (deliverLeft_q == LEN_W'(1)))    state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Burst bookkeeping: grant/pointer, cursors, address and word counters.
   // The pointer moves at grant time; cfg_rdy is not looked at again until
   // the burst is back in IDLE, so this is indistinguishable from moving it
   // at the end of the burst.
   always_comb begin
      ptr_d         = ptr_q;
      grant_d       = grant_q;
      cur_d         = cur_q;
      addr_d        = addr_q;
      issueLeft_d   = issueLeft_q;
      deliverLeft_d = deliverLeft_q;
      if ((state_q == S_IDLE) && !cmd_vld && rrHit) begin
         grant_d       = rrIdx;
         ptr_d         = rrIdx;
         issueLeft_d   = isa_num[int'(rrIdx)*LEN_W +: LEN_W];
         deliverLeft_d = isa_num[int'(rrIdx)*LEN_W +: LEN_W];
      end
      if (cmdHs) begin
         addr_d        = dat_in[1 +: MEM_AW];
         issueLeft_d   = dat_in[1+MEM_AW +: LEN_W];
         deliverLeft_d = dat_in[1+MEM_AW +: LEN_W];
      end
      if (issue) begin
         issueLeft_d = issueLeft_q - LEN_W'(1);
         if (state_q == S_RD) addr_d = addr_q + MEM_AW'(1);
         if (state_q == S_ISA) begin
            if (cur_q[grant_q] == CW'(ISA_DEPTH-1)) cur_d[grant_q] = '0;
            else                                    cur_d[grant_q] = cur_q[grant_q] + CW'(1);
         end
      end
      if (pop) deliverLeft_d = deliverLeft_q - LEN_W'(1);
      if (wrHs) begin
         addr_d        = addr_q + MEM_AW'(1);
         deliverLeft_d = deliverLeft_q - LEN_W'(1);
      end
   end

   // Return buffer: the word arriving from SRAM this cycle is served directly
   // when the buffer is empty, and parked in the buffer when it cannot leave
   always_comb begin
      bufCnt_d   = bufCnt_q;
      buf0_d     = buf0_q;
      buf1_d     = buf1_q;
      inflight_d = issue;
      case (bufCnt_q)
         2'd0: begin
            if (inflight_q && !pop) begin
               buf0_d   = mem_rdata;
               bufCnt_d = 2'd1;
            end
         end
         2'd1: begin
            if (pop) begin
               if (inflight_q) buf0_d   = mem_rdata;
               else            bufCnt_d = 2'd0;
            end else if (inflight_q) begin
               buf1_d   = mem_rdata;
               bufCnt_d = 2'd2;
            end
         end
         default: begin
            if (pop) begin
               buf0_d   = buf1_q;
               bufCnt_d = 2'd1;
            end
         end
      endcase
      if (!reading) begin
         bufCnt_d   = 2'd0;
         inflight_d = 1'b0;
      end
   end

   // State, bookkeeping and buffer registers; reset aborts any burst at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         ptr_q         <= GW'(NUM_OP-1);
         grant_q       <= '0;
         for (int c = 0; c < NUM_OP; c++) cur_q[c] <= '0;
         addr_q        <= '0;
         issueLeft_q   <= '0;
         deliverLeft_q <= '0;
         inflight_q    <= 1'b0;
         bufCnt_q      <= 2'd0;
         buf0_q        <= '0;
         buf1_q        <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         grant_q       <= grant_d;
         cur_q         <= cur_d;
         addr_q        <= addr_d;
         issueLeft_q   <= issueLeft_d;
         deliverLeft_q <= deliverLeft_d;
         inflight_q    <= inflight_d;
         bufCnt_q      <= bufCnt_d;
         buf0_q        <= buf0_d;
         buf1_q        <= buf1_d;
      end
   end

endmodule
